sseg_ctrl: RTL and testbench

SSEG_CTRL -- requirements
Module: sseg_ctrl

---
 rtl/sseg_pkg.sv | 17 +
 rtl/sseg_tick_gen.sv | 40 ++++
 rtl/sseg_ctrl.sv | 105 ++++++++++
 tb/tb_sseg_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display controller.
package sseg_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned DISP_W   = DIGIT_W * N_DIGITS;
    localparam int unsigned SCAN_W   = $clog2(N_DIGITS);

    typedef logic [DISP_W-1:0] disp_word_t;

    typedef enum logic [1:0] {
        StIdle,
        StWaitFrame,
        StCommit
    } sseg_state_e;

endpackage

// File: rtl/sseg_tick_gen.sv
// Free-running scan prescaler and digit scan index; frame_end marks the last digit's tick.
module sseg_tick_gen
    import sseg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              enabled,
    output logic [SCAN_W-1:0] scan_idx,
    output logic              frame_end
);

    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0]   CntMax  = CntW'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] IdxLast = SCAN_W'(N_DIGITS - 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [SCAN_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        enabled = (cnt_q == CntMax);
        cnt_d   = enabled ? '0 : cnt_q + 1'b1;
        idx_d   = enabled ? idx_q + 1'b1 : idx_q;
    end

    assign scan_idx  = idx_q;
    assign frame_end = enabled && (idx_q == IdxLast);

endmodule

// File: rtl/sseg_ctrl.sv
// Two-requester display controller: round-robin accept, then commit on a frame boundary
// so the driver never shows a torn frame.
module sseg_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_a_valid,
    input  logic [DISP_W-1:0]  req_a_data,
    output logic               req_a_ready,
    input  logic               req_b_valid,
    input  logic [DISP_W-1:0]  req_b_data,
    output logic               req_b_ready,
    output logic               enabled,
    output logic [DIGIT_W-1:0] digit0,
    output logic [DIGIT_W-1:0] digit1,
    output logic [DIGIT_W-1:0] digit2,
    output logic [DIGIT_W-1:0] digit3,
    output logic               busy
);

    sseg_state_e       state_q, state_d;
    disp_word_t        pending_q, pending_d;
    disp_word_t        digits_q, digits_d;
    logic              prio_b_q, prio_b_d;
    logic [SCAN_W-1:0] scan_idx;
    logic              frame_end;
    logic              grant_a, grant_b, xfer;

    sseg_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .enabled   (enabled),
        .scan_idx  (scan_idx),
        .frame_end (frame_end)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (xfer)      state_d = StWaitFrame;
            StWaitFrame: if (frame_end) state_d = StCommit;
            StCommit:                   state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    // Outputs; prio_b_q set means B wins a tie.
    always_comb begin
        grant_a     = req_a_valid && (!req_b_valid || !prio_b_q);
        grant_b     = req_b_valid && (!req_a_valid || prio_b_q);
        req_a_ready = !rst && (state_q == StIdle) && grant_a;
        req_b_ready = !rst && (state_q == StIdle) && grant_b;
        xfer        = req_a_ready || req_b_ready;
        busy        = (state_q != StIdle);
    end

    always_comb begin
        pending_d = pending_q;
        prio_b_d  = prio_b_q;
        digits_d  = digits_q;
        if (req_a_ready) begin
            pending_d = req_a_data;
            prio_b_d  = 1'b1;
        end else if (req_b_ready) begin
            pending_d = req_b_data;
            prio_b_d  = 1'b0;
        end
        if (state_q == StCommit) begin
            digits_d = pending_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            digits_q  <= '0;
            prio_b_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            digits_q  <= digits_d;
            prio_b_q  <= prio_b_d;
        end
    end

    assign digit0 = digits_q[DIGIT_W-1:0];
    assign digit1 = digits_q[2*DIGIT_W-1:DIGIT_W];
    assign digit2 = digits_q[3*DIGIT_W-1:2*DIGIT_W];
    assign digit3 = digits_q[4*DIGIT_W-1:3*DIGIT_W];

endmodule

// File: tb/tb_sseg_ctrl.sv
// Scoreboard bench for sseg_ctrl with a four-cycle scan tick.
module tb_sseg_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [15:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, enabled, busy;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic [15:0] disp;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    int          m_cnt = 0;
    logic [1:0]  m_idx = '0;
    logic [1:0]  fe_hist = '0;
    logic        busy_prev = 1'b0;

    always #5 clk = ~clk;

    assign disp = {digit3, digit2, digit1, digit0};

    sseg_ctrl #(
        .TICK_DIV (TD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_a_valid (a_valid),
        .req_a_data  (a_data),
        .req_a_ready (a_ready),
        .req_b_valid (b_valid),
        .req_b_data  (b_data),
        .req_b_ready (b_ready),
        .enabled     (enabled),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .busy        (busy)
    );

    // Reference tick model; fe_hist[1] marks a frame_end two edges ago.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cnt   = 0;
            m_idx   = '0;
            fe_hist = '0;
        end else begin
            fe_hist = {fe_hist[0], (m_cnt == TD - 1) && (m_idx == 2'd3)};
            if (m_cnt == TD - 1) begin
                m_cnt = 0;
                m_idx = m_idx + 2'd1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    // Continuous monitor; pops the scoreboard on every commit.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            busy_prev = 1'b0;
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_reset: a=%b b=%b required 0 0", a_ready, b_ready);
            end
        end else begin
            checks++;
            if (enabled !== (m_cnt == TD - 1)) begin
                errors++;
                $display("FAIL enabled_timing: got %b required %b", enabled, m_cnt == TD - 1);
            end
            checks++;
            if (busy ? (a_ready || b_ready)
                     : ((a_ready && b_ready) || ((a_ready || b_ready) !== (a_valid || b_valid))))
            begin
                errors++;
                $display("FAIL ready_rule: busy=%b av=%b bv=%b ar=%b br=%b",
                         busy, a_valid, b_valid, a_ready, b_ready);
            end
            if (busy_prev && !busy) begin
                checks++;
                if (fe_hist !== 2'b10) begin
                    errors++;
                    $display("FAIL commit_timing: fe_hist %b required 10", fe_hist);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_commit: digits %h with empty scoreboard", disp);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (disp !== e) begin
                        errors++;
                        $display("FAIL commit_value: got %h required %h", disp, e);
                    end
                end
            end
            busy_prev = busy;
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles required 0", busy, n);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0 || enabled !== 1'b0 || busy !== 1'b0
            || disp !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: ar=%b br=%b en=%b busy=%b disp=%h required all 0",
                     a_ready, b_ready, enabled, busy, disp);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Release happens at the start of cycle 1.
    task automatic test_tick();
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            checks++;
            if (enabled !== (n % TD == 0) || disp !== 16'h0 || a_ready || b_ready) begin
                errors++;
                $display("FAIL idle_tick c%0d: en=%b disp=%h required en=%b disp=0000",
                         n, enabled, disp, n % TD == 0);
            end
        end
    endtask

    task automatic test_single();
        int n;
        exp_q.push_back(16'h1234);
        @(posedge clk);
        #1 a_valid = 1'b1;
        a_data = 16'h1234;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: a=%b b=%b required 1 0", a_ready, b_ready);
        end
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || disp !== 16'h0) begin
            errors++;
            $display("FAIL single_busy: busy=%b disp=%h required 1 0000", busy, disp);
        end
        wait_idle(n);
        checks++;
        if (n != 4 || disp !== 16'h1234) begin
            errors++;
            $display("FAIL single_commit: after %0d cycles disp=%h required 4 1234", n, disp);
        end
    endtask

    task automatic test_both();
        int n;
        bit got_b = 1'b0;
        exp_q.push_back(16'hAAAA);
        exp_q.push_back(16'hBBBB);
        @(posedge clk);
        #1 rst = 1'b1;
        a_valid = 1'b1;
        a_data  = 16'hAAAA;
        b_valid = 1'b1;
        b_data  = 16'hBBBB;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL both_first_grant: a=%b b=%b required 1 0", a_ready, b_ready);
        end
        @(posedge clk);
        #1 a_valid = 1'b0;
        for (int i = 0; i < 100 && !got_b; i++) begin
            @(negedge clk);
            got_b = b_ready;
        end
        checks++;
        if (!got_b) begin
            errors++;
            $display("FAIL both_b_grant: b_ready never rose required 1");
        end
        @(posedge clk);
        #1 b_valid = 1'b0;
        wait_idle(n);
        checks++;
        if (disp !== 16'hBBBB) begin
            errors++;
            $display("FAIL both_final: disp=%h required bbbb", disp);
        end
    endtask

    // Both requesters stay valid; A re-offers after its first accept and must lose to B.
    task automatic test_back_to_back();
        int n;
        int a_cnt = 0;
        int guard = 0;
        bit a_acc, b_acc;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        exp_q.push_back(16'h3333);
        @(posedge clk);
        #1 a_valid = 1'b1;
        a_data  = 16'h1111;
        b_valid = 1'b1;
        b_data  = 16'h2222;
        while ((a_valid || b_valid) && guard < 300) begin
            @(negedge clk);
            a_acc = a_valid && a_ready;
            b_acc = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (a_acc) begin
                if (a_cnt == 0) a_data = 16'h3333;
                else            a_valid = 1'b0;
                a_cnt++;
            end
            if (b_acc) b_valid = 1'b0;
            guard++;
        end
        checks++;
        if (a_valid || b_valid) begin
            errors++;
            $display("FAIL b2b_timeout: av=%b bv=%b required 0 0", a_valid, b_valid);
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
        wait_idle(n);
    endtask

    task automatic test_frame_edge();
        int n;
        int guard = 0;
        exp_q.push_back(16'h9ABC);
        do begin
            @(negedge clk);
            guard++;
        end while (!(m_cnt == TD - 2 && m_idx == 2'd3) && guard < 100);
        @(posedge clk);
        #1 a_valid = 1'b1;
        a_data = 16'h9ABC;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || enabled !== 1'b1) begin
            errors++;
            $display("FAIL edge_accept: ready=%b en=%b required 1 1", a_ready, enabled);
        end
        @(posedge clk);
        #1 a_valid = 1'b0;
        wait_idle(n);
        checks++;
        if (n != 18 || disp !== 16'h9ABC) begin
            errors++;
            $display("FAIL edge_commit: after %0d cycles disp=%h required 18 9abc", n, disp);
        end
    endtask

    task automatic test_reset_wait();
        @(posedge clk);
        #1 a_valid = 1'b1;
        a_data = 16'h5678;
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstw_busy: busy=%b required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || disp !== 16'h0 || enabled !== 1'b0) begin
            errors++;
            $display("FAIL rstw_reset: busy=%b disp=%h en=%b required 0 0000 0",
                     busy, disp, enabled);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (enabled !== (c == 4) || busy !== 1'b0 || disp !== 16'h0) begin
                errors++;
                $display("FAIL rstw_after c%0d: en=%b busy=%b disp=%h required %b 0 0000",
                         c, enabled, busy, disp, c == 4);
            end
        end
    endtask

    task automatic test_hold_b();
        int n;
        int b_acc = 0;
        exp_q.push_back(16'h1357);
        exp_q.push_back(16'h2468);
        @(posedge clk);
        #1 a_valid = 1'b1;
        a_data = 16'h1357;
        @(posedge clk);
        #1 a_valid = 1'b0;
        b_valid = 1'b1;
        b_data  = 16'h2468;
        for (int i = 0; i < 100 && b_valid; i++) begin
            @(negedge clk);
            if (b_ready) begin
                b_acc++;
                checks++;
                if (busy !== 1'b0 || disp !== 16'h1357) begin
                    errors++;
                    $display("FAIL holdb_grant: busy=%b disp=%h required 0 1357", busy, disp);
                end
                @(posedge clk);
                #1 b_valid = 1'b0;
            end
        end
        b_valid = 1'b0;
        wait_idle(n);
        checks++;
        if (b_acc != 1 || disp !== 16'h2468) begin
            errors++;
            $display("FAIL holdb_final: accepts=%0d disp=%h required 1 2468", b_acc, disp);
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_single();
        test_both();
        test_back_to_back();
        test_frame_edge();
        test_reset_wait();
        test_hold_b();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
